// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S / MSB-justified transmit shifter fed by a show-ahead Tx FIFO.
// Loads one word per L/R slot opened by the WS control stage and shifts it MSB-first on sd.
// Optional feature macro: TX_UNDERRUN_REPEAT_EN (on underrun, resend the last popped word).

package ctrl_pkg;
  typedef enum logic [1:0] {
    WS_IDLE = 2'b00,
    WS_L    = 2'b01,
    WS_R    = 2'b10
  } ws_state_t;

  typedef enum logic {
    F16BITS = 1'b0,
    F32BITS = 1'b1
  } frame_size_t;

  typedef enum logic {
    STD_I2S = 1'b0,
    STD_MSB = 1'b1
  } standard_t;
endpackage

module i2s_tx_serializer
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              sclk,
  input  logic              preset,
  input  logic [1:0]        ws_state,
  input  logic              tx_ren,
  input  logic              frame_size,
  input  logic              standard,
  input  logic              stop,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  input  logic              underrun_clr,
  output logic              fifo_rd,
  output logic              sd,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned PAD_W = DATA_W - 31;
  localparam int unsigned CNT_W = 6;

  logic [1:0]        r_ws_prev;
  logic [DATA_W:0]   r_shreg;
  logic [CNT_W-1:0]  r_bitcnt;
  logic              r_sd;
  logic              r_underrun;

  logic              w_start;
  logic              w_underrun_set;
  logic [31:0]       w_load;
  logic [31:0]       w_frame;
  logic [DATA_W:0]   w_aligned;
  logic [CNT_W-1:0]  w_frame_len;

  logic [1:0]        w_ws_prev_nxt;
  logic [DATA_W:0]   w_shreg_nxt;
  logic [CNT_W-1:0]  w_bitcnt_nxt;
  logic              w_sd_nxt;
  logic              w_underrun_nxt;

  // A slot opens on the first cycle WS enters L or R, unless frozen
  assign w_start = ((ws_state == WS_L) || (ws_state == WS_R)) &&
                   (ws_state != r_ws_prev) && !stop;

  assign w_underrun_set = w_start && tx_ren && fifo_empty;

  // Pop is combinational so the FIFO advances on the same edge the word is loaded
  assign fifo_rd = preset && w_start && tx_ren && !fifo_empty;

`ifdef TX_UNDERRUN_REPEAT_EN
  logic [31:0] r_last_word;

  // Remember the most recent popped word for underrun repeat
  always_ff @(negedge sclk) begin
    if (!preset) begin
      r_last_word <= 32'd0;
    end else if (fifo_rd) begin
      r_last_word <= fifo_rdata[31:0];
    end
  end

  assign w_load = fifo_rd ? fifo_rdata[31:0] :
                  (w_underrun_set ? r_last_word : 32'd0);
`else
  assign w_load = fifo_rd ? fifo_rdata[31:0] : 32'd0;
`endif

  // 16-bit frames use the low half, moved up so bit 15 lands in the MSB slot
  assign w_frame     = (frame_size == F32BITS) ? w_load : {w_load[15:0], 16'h0000};
  assign w_aligned   = {w_frame, {PAD_W{1'b0}}};
  assign w_frame_len = (frame_size == F32BITS) ? CNT_W'(32) : CNT_W'(16);

  // Next-state for shifter, counter, WS history and underrun flag
  always_comb begin
    w_ws_prev_nxt  = r_ws_prev;
    w_shreg_nxt    = r_shreg;
    w_bitcnt_nxt   = r_bitcnt;
    w_sd_nxt       = r_sd;
    w_underrun_nxt = r_underrun;

    if (!stop) begin
      w_ws_prev_nxt = ws_state;
      if (w_start) begin
        if (standard == STD_MSB) begin
          w_sd_nxt     = w_frame[31];
          w_shreg_nxt  = {w_aligned[DATA_W-1:0], 1'b0};
          w_bitcnt_nxt = w_frame_len - CNT_W'(1);
        end else begin
          // I2S one-bit delay: the pending bit (old LSB or 0) goes out first
          w_sd_nxt     = r_shreg[DATA_W];
          w_shreg_nxt  = w_aligned;
          w_bitcnt_nxt = w_frame_len;
        end
      end else if (r_bitcnt != '0) begin
        w_sd_nxt     = r_shreg[DATA_W];
        w_shreg_nxt  = {r_shreg[DATA_W-1:0], 1'b0};
        w_bitcnt_nxt = r_bitcnt - CNT_W'(1);
      end else begin
        w_sd_nxt = 1'b0;
      end
    end

    // Set has priority over clear on the same edge
    if (w_underrun_set) begin
      w_underrun_nxt = 1'b1;
    end else if (underrun_clr) begin
      w_underrun_nxt = 1'b0;
    end
  end

  // State registers with synchronous active-low reset on the falling edge
  always_ff @(negedge sclk) begin
    if (!preset) begin
      r_ws_prev  <= WS_IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_ws_prev  <= w_ws_prev_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_sd       <= w_sd_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign sd       = r_sd;
  assign busy     = (r_bitcnt != '0);
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed testbench for i2s_tx_serializer with a small show-ahead FIFO model.
module tb_i2s_tx_serializer;
  import ctrl_pkg::*;

  logic        sclk;
  logic        preset;
  logic [1:0]  ws_state;
  logic        tx_ren;
  logic        frame_size;
  logic        standard;
  logic        stop;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        underrun_clr;
  logic        fifo_rd;
  logic        sd;
  logic        busy;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  logic [31:0] got;
  logic [31:0] exp_ur;
  logic        seen_rd;
  logic        seen_sd;

  i2s_tx_serializer #(.DATA_W(32)) dut (
    .sclk         (sclk),
    .preset       (preset),
    .ws_state     (ws_state),
    .tx_ren       (tx_ren),
    .frame_size   (frame_size),
    .standard     (standard),
    .stop         (stop),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .underrun_clr (underrun_clr),
    .fifo_rd      (fifo_rd),
    .sd           (sd),
    .busy         (busy),
    .underrun     (underrun)
  );

  initial begin
    sclk = 1'b1;
    forever #5 sclk = ~sclk;
  end

  // Show-ahead FIFO model: head word visible, pop on the falling edge
  assign fifo_rdata = mem[rd_ptr[3:0]];
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(negedge sclk) begin
    if (fifo_rd) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    preset       = 1'b0;
    ws_state     = WS_IDLE;
    tx_ren       = 1'b0;
    frame_size   = F32BITS;
    standard     = STD_MSB;
    stop         = 1'b0;
    underrun_clr = 1'b0;
    tick();
    tick();
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    preset = 1'b1;
    tick();

    // MSB standard, 32-bit frame
    push(32'hA5A5_0F0F);
    tx_ren   = 1'b1;
    ws_state = WS_L;
    #1;
    check("t1_fifo_rd", 32'(fifo_rd), 32'd1);
    tick();
    check("t1_rd_once", 32'(fifo_rd), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    got = '0;
    got[31] = sd;
    for (int i = 30; i >= 0; i--) begin
      tick();
      got[i] = sd;
    end
    check("t1_word", got, 32'hA5A5_0F0F);
    check("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check("t1_sd_after", 32'(sd), 32'd0);
    check("t1_pops", 32'(pop_cnt), 32'd1);

    // I2S standard, 16-bit stereo
    ws_state = WS_IDLE;
    tick();
    push(32'h0000_8001);
    push(32'h0000_7FFE);
    standard   = STD_I2S;
    frame_size = F16BITS;
    ws_state   = WS_L;
    tick();
    check("t2_l_first", 32'(sd), 32'd0);
    got = '0;
    for (int i = 15; i >= 1; i--) begin
      tick();
      got[i] = sd;
    end
    ws_state = WS_R;
    #1;
    check("t2_r_rd", 32'(fifo_rd), 32'd1);
    tick();
    got[0] = sd;
    check("t2_l_word", got, 32'h0000_8001);
    got = '0;
    for (int i = 15; i >= 1; i--) begin
      tick();
      got[i] = sd;
    end
    ws_state = WS_IDLE;
    tick();
    got[0] = sd;
    check("t2_r_word", got, 32'h0000_7FFE);
    tick();
    check("t2_sd_after", 32'(sd), 32'd0);
    check("t2_pops", 32'(pop_cnt), 32'd3);

    // Underrun: FIFO empty at slot start
    standard = STD_MSB;
    ws_state = WS_L;
    #1;
    check("t3_no_rd", 32'(fifo_rd), 32'd0);
    tick();
    check("t3_underrun", 32'(underrun), 32'd1);
    got = '0;
    got[15] = sd;
    for (int i = 14; i >= 0; i--) begin
      tick();
      got[i] = sd;
    end
`ifdef TX_UNDERRUN_REPEAT_EN
    exp_ur = 32'h0000_7FFE;
`else
    exp_ur = 32'h0000_0000;
`endif
    check("t3_ur_word", got, exp_ur);
    check("t3_pops", 32'(pop_cnt), 32'd3);
    ws_state     = WS_IDLE;
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t3_clr", 32'(underrun), 32'd0);

    // Stop held for three cycles after ten bits
    push(32'h1234_5678);
    frame_size = F32BITS;
    ws_state   = WS_L;
    tick();
    got = '0;
    got[31] = sd;
    for (int i = 30; i >= 22; i--) begin
      tick();
      got[i] = sd;
    end
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_sd", 32'(sd), 32'(got[22]));
      check("t4_hold_busy", 32'(busy), 32'd1);
    end
    stop = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      tick();
      got[i] = sd;
    end
    check("t4_word", got, 32'h1234_5678);
    check("t4_busy_end", 32'(busy), 32'd0);

    // Set and clear on the same edge: set wins
    ws_state = WS_IDLE;
    tick();
    ws_state     = WS_R;
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t5_set_wins", 32'(underrun), 32'd1);
    ws_state = WS_IDLE;
    repeat (33) tick();

    // Reset in the middle of a slot
    push(32'hFFFF_FFFF);
    push(32'h8000_0001);
    ws_state = WS_L;
    tick();
    check("t6_first", 32'(sd), 32'd1);
    repeat (4) tick();
    check("t6_busy_mid", 32'(busy), 32'd1);
    preset   = 1'b0;
    ws_state = WS_R;
    #1;
    check("t6_rst_no_rd", 32'(fifo_rd), 32'd0);
    tick();
    check("t6_rst_sd", 32'(sd), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_underrun", 32'(underrun), 32'd0);
    check("t6_rst_pops", 32'(pop_cnt), 32'd5);
    preset   = 1'b1;
    ws_state = WS_IDLE;
    tick();
    ws_state = WS_L;
    #1;
    check("t6_next_rd", 32'(fifo_rd), 32'd1);
    tick();
    got = '0;
    got[31] = sd;
    for (int i = 30; i >= 0; i--) begin
      tick();
      got[i] = sd;
    end
    check("t6_word", got, 32'h8000_0001);
    check("t6_pops", 32'(pop_cnt), 32'd6);

    // Receive mode: slots open with tx_ren low
    ws_state = WS_IDLE;
    tick();
    tx_ren = 1'b0;
    push(32'hCAFE_BABE);
    seen_rd = 1'b0;
    seen_sd = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ws_state = (s % 2 == 0) ? WS_L : WS_R;
      repeat (8) begin
        #1;
        seen_rd = seen_rd | fifo_rd;
        tick();
        seen_sd = seen_sd | sd;
      end
    end
    check("t7_no_rd", 32'(seen_rd), 32'd0);
    check("t7_sd_zero", 32'(seen_sd), 32'd0);
    check("t7_no_underrun", 32'(underrun), 32'd0);
    check("t7_pops", 32'(pop_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
